// File: rtl/uart_apb_regs_if.sv
// APB3 bus bundle between a bus master and the UART register bank.
interface uart_apb_regs_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [4:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/uart_apb_regs.sv
// APB3 register bank in front of the UART core: strobe generation, line
// configuration, status/sticky drop flag and the level interrupt.
//
// state  | meaning
// IDLE   | no transfer in flight
// SETUP  | setup phase was sampled; the bus is now in its access cycle
// ACCESS | access cycle completed; a back-to-back setup may follow
module uart_apb_regs #(
  parameter logic [12:0] BAUD_RESET = 13'd1,
  parameter logic [2:0]  FRAC_RESET = 3'd0
) (
  input  logic           CLK,
  input  logic           RESET_N,
  uart_apb_regs_if.slave apb,
  output logic           UART_CSN,
  output logic           UART_WEN,
  output logic           UART_OEN,
  output logic [7:0]     UART_DATA_IN,
  input  logic [7:0]     UART_DATA_OUT,
  input  logic           TXRDY,
  input  logic           RXRDY,
  input  logic           PARITY_ERR,
  input  logic           OVERFLOW,
  input  logic           FRAMING_ERR,
  output logic [12:0]    BAUD_VAL,
  output logic [2:0]     BAUD_VAL_FRACTION,
  output logic           BIT8,
  output logic           PARITY_EN,
  output logic           ODD_N_EVEN,
  output logic           INTR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [2:0] A_TX    = 3'd0;
  localparam logic [2:0] A_RX    = 3'd1;
  localparam logic [2:0] A_CTRL1 = 3'd2;
  localparam logic [2:0] A_CTRL2 = 3'd3;
  localparam logic [2:0] A_STAT  = 3'd4;
  localparam logic [2:0] A_CTRL3 = 3'd5;

  state_t      state_q, state_d;
  logic        csn_q, csn_d;
  logic        wen_q, wen_d;
  logic        oen_q, oen_d;
  logic        drop_pend_q, drop_pend_d;
  logic [7:0]  data_in_q, data_in_d;
  logic [12:0] baud_q, baud_d;
  logic [2:0]  frac_q, frac_d;
  logic        bit8_q, bit8_d;
  logic        par_q, par_d;
  logic        odd_q, odd_d;
  logic        ie_rx_q, ie_rx_d;
  logic        ie_tx_q, ie_tx_d;
  logic        ie_err_q, ie_err_d;
  logic        tx_drop_q, tx_drop_d;
  logic        intr_q, intr_d;

  logic        setup_ph;
  logic        acc_ph;
  logic        access_ok;
  logic        wr_ok;
  logic        tx_go;
  logic        rx_go;
  logic        slverr_c;
  logic [2:0]  idx;
  logic [7:0]  rdata_c;
  logic        unused_addr_lo;

  assign setup_ph       = apb.PSEL & ~apb.PENABLE;
  assign acc_ph         = apb.PSEL & apb.PENABLE;
  assign idx            = apb.PADDR[4:2];
  assign unused_addr_lo = ^apb.PADDR[1:0];
  assign access_ok      = (state_q == SETUP) & acc_ph;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (setup_ph) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = setup_ph ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A TX write that found the core busy errors out even though the address is legal.
  always_comb begin
    slverr_c = 1'b0;
    case (idx)
      A_TX:    slverr_c = ~apb.PWRITE | drop_pend_q;
      A_RX:    slverr_c = apb.PWRITE;
      A_STAT:  slverr_c = apb.PWRITE & (|(apb.PWDATA & 8'hDF));
      A_CTRL1,
      A_CTRL2,
      A_CTRL3: slverr_c = 1'b0;
      default: slverr_c = 1'b1;
    endcase
  end

  always_comb begin
    rdata_c = 8'h00;
    case (idx)
      A_RX:    rdata_c = UART_DATA_OUT;
      A_CTRL1: rdata_c = baud_q[7:0];
      A_CTRL2: rdata_c = {baud_q[12:8], odd_q, par_q, bit8_q};
      A_STAT:  rdata_c = {2'b00, tx_drop_q, FRAMING_ERR, OVERFLOW, PARITY_ERR, RXRDY, TXRDY};
      A_CTRL3: rdata_c = {2'b00, ie_err_q, ie_tx_q, ie_rx_q, frac_q};
      default: rdata_c = 8'h00;
    endcase
  end

  assign tx_go = setup_ph & apb.PWRITE & (idx == A_TX) & TXRDY;
  assign rx_go = setup_ph & ~apb.PWRITE & (idx == A_RX);
  assign wr_ok = access_ok & apb.PWRITE & ~slverr_c;

  always_comb begin
    csn_d       = ~(tx_go | rx_go);
    wen_d       = ~tx_go;
    oen_d       = ~rx_go;
    drop_pend_d = setup_ph & apb.PWRITE & (idx == A_TX) & ~TXRDY;
    data_in_d   = tx_go ? apb.PWDATA : data_in_q;
    baud_d      = baud_q;
    frac_d      = frac_q;
    bit8_d      = bit8_q;
    par_d       = par_q;
    odd_d       = odd_q;
    ie_rx_d     = ie_rx_q;
    ie_tx_d     = ie_tx_q;
    ie_err_d    = ie_err_q;
    tx_drop_d   = tx_drop_q;

    if (wr_ok) begin
      case (idx)
        A_CTRL1: baud_d[7:0] = apb.PWDATA;
        A_CTRL2: begin
          bit8_d       = apb.PWDATA[0];
          par_d        = apb.PWDATA[1];
          odd_d        = apb.PWDATA[2];
          baud_d[12:8] = apb.PWDATA[7:3];
        end
        A_CTRL3: begin
          frac_d   = apb.PWDATA[2:0];
          ie_rx_d  = apb.PWDATA[3];
          ie_tx_d  = apb.PWDATA[4];
          ie_err_d = apb.PWDATA[5];
        end
        A_STAT:  if (apb.PWDATA[5]) tx_drop_d = 1'b0;
        default: ;
      endcase
    end

    // Set is applied last so it beats a simultaneous clear.
    if (access_ok & drop_pend_q) tx_drop_d = 1'b1;

    intr_d = (ie_rx_q & RXRDY) | (ie_tx_q & TXRDY) |
             (ie_err_q & (PARITY_ERR | OVERFLOW | FRAMING_ERR | tx_drop_q));
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      csn_q       <= 1'b1;
      wen_q       <= 1'b1;
      oen_q       <= 1'b1;
      drop_pend_q <= 1'b0;
      data_in_q   <= 8'h00;
      baud_q      <= BAUD_RESET;
      frac_q      <= FRAC_RESET;
      bit8_q      <= 1'b1;
      par_q       <= 1'b0;
      odd_q       <= 1'b0;
      ie_rx_q     <= 1'b0;
      ie_tx_q     <= 1'b0;
      ie_err_q    <= 1'b0;
      tx_drop_q   <= 1'b0;
      intr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      csn_q       <= csn_d;
      wen_q       <= wen_d;
      oen_q       <= oen_d;
      drop_pend_q <= drop_pend_d;
      data_in_q   <= data_in_d;
      baud_q      <= baud_d;
      frac_q      <= frac_d;
      bit8_q      <= bit8_d;
      par_q       <= par_d;
      odd_q       <= odd_d;
      ie_rx_q     <= ie_rx_d;
      ie_tx_q     <= ie_tx_d;
      ie_err_q    <= ie_err_d;
      tx_drop_q   <= tx_drop_d;
      intr_q      <= intr_d;
    end
  end

  // Gating with the live access phase keeps a dropped PSEL from reaching the core.
  assign UART_CSN = csn_q | ~acc_ph;
  assign UART_WEN = wen_q | ~acc_ph;
  assign UART_OEN = oen_q | ~acc_ph;

  assign UART_DATA_IN      = data_in_q;
  assign BAUD_VAL          = baud_q;
  assign BAUD_VAL_FRACTION = frac_q;
  assign BIT8              = bit8_q;
  assign PARITY_EN         = par_q;
  assign ODD_N_EVEN        = odd_q;
  assign INTR              = intr_q;

  assign apb.PRDATA  = (access_ok & ~apb.PWRITE) ? rdata_c : 8'h00;
  assign apb.PSLVERR = access_ok & slverr_c;
  assign apb.PREADY  = 1'b1;

endmodule

// File: tb/tb_uart_apb_regs.sv
// Bench for uart_apb_regs: directed register-map scenarios plus random APB traffic
// against a behavioural model of the register bank.
module tb_uart_apb_regs;
  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        UART_CSN, UART_WEN, UART_OEN;
  logic [7:0]  UART_DATA_IN;
  logic [7:0]  UART_DATA_OUT;
  logic        TXRDY, RXRDY, PARITY_ERR, OVERFLOW, FRAMING_ERR;
  logic [12:0] BAUD_VAL;
  logic [2:0]  BAUD_VAL_FRACTION;
  logic        BIT8, PARITY_EN, ODD_N_EVEN, INTR;

  always #5 CLK = ~CLK;

  uart_apb_regs_if bus();

  uart_apb_regs #(.BAUD_RESET(13'd1), .FRAC_RESET(3'd0)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .apb(bus),
    .UART_CSN(UART_CSN), .UART_WEN(UART_WEN), .UART_OEN(UART_OEN),
    .UART_DATA_IN(UART_DATA_IN), .UART_DATA_OUT(UART_DATA_OUT),
    .TXRDY(TXRDY), .RXRDY(RXRDY), .PARITY_ERR(PARITY_ERR),
    .OVERFLOW(OVERFLOW), .FRAMING_ERR(FRAMING_ERR),
    .BAUD_VAL(BAUD_VAL), .BAUD_VAL_FRACTION(BAUD_VAL_FRACTION),
    .BIT8(BIT8), .PARITY_EN(PARITY_EN), .ODD_N_EVEN(ODD_N_EVEN), .INTR(INTR)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of software-visible state
  logic [12:0] m_baud;
  logic [2:0]  m_frac;
  logic        m_bit8, m_par, m_odd, m_ie_rx, m_ie_tx, m_ie_err, m_drop;
  logic [7:0]  m_data_in;
  logic        m_intr;
  logic        exp_csn, exp_wen, exp_oen, exp_acc, exp_rd, exp_err;
  logic [7:0]  exp_prdata;
  logic        prev_csn;
  int          cnt_csn = 0, cnt_wen = 0, cnt_oen = 0;

  task automatic model_reset();
    m_baud = 13'd1; m_frac = 3'd0; m_bit8 = 1'b1; m_par = 1'b0; m_odd = 1'b0;
    m_ie_rx = 1'b0; m_ie_tx = 1'b0; m_ie_err = 1'b0; m_drop = 1'b0;
    m_data_in = 8'h00;
    exp_csn = 1'b1; exp_wen = 1'b1; exp_oen = 1'b1;
    exp_acc = 1'b0; exp_rd = 1'b0; exp_err = 1'b0; exp_prdata = 8'h00;
    prev_csn = 1'b1;
  endtask

  function automatic logic [7:0] model_read(input int a);
    case (a)
      1: return UART_DATA_OUT;
      2: return m_baud[7:0];
      3: return {m_baud[12:8], m_odd, m_par, m_bit8};
      4: return {2'b00, m_drop, FRAMING_ERR, OVERFLOW, PARITY_ERR, RXRDY, TXRDY};
      5: return {2'b00, m_ie_err, m_ie_tx, m_ie_rx, m_frac};
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic model_err(input logic wr, input int a, input logic [7:0] d,
                                     input logic txrdy);
    if (a >= 6) return 1'b1;
    if (a == 0) return !wr || !txrdy;
    if (a == 1) return wr;
    if (a == 4) return wr && ((d & 8'hDF) != 8'h00);
    return 1'b0;
  endfunction

  // Interrupt is the registered OR of enabled sources.
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) m_intr <= 1'b0;
    else m_intr <= (m_ie_rx && RXRDY) || (m_ie_tx && TXRDY) ||
                   (m_ie_err && (PARITY_ERR || OVERFLOW || FRAMING_ERR || m_drop));
  end

  always @(negedge CLK) begin
    if (RESET_N) begin
      chk("csn", UART_CSN, exp_csn);
      chk("wen", UART_WEN, exp_wen);
      chk("oen", UART_OEN, exp_oen);
      chk("data_in", UART_DATA_IN, m_data_in);
      chk("baud_val", BAUD_VAL, m_baud);
      chk("baud_frac", BAUD_VAL_FRACTION, m_frac);
      chk("line_cfg", {BIT8, PARITY_EN, ODD_N_EVEN}, {m_bit8, m_par, m_odd});
      chk("intr", INTR, m_intr);
      chk("pready", bus.PREADY, 1'b1);
      if (exp_acc) begin
        chk("pslverr", bus.PSLVERR, exp_err);
        if (exp_rd) chk("prdata", bus.PRDATA, exp_prdata);
      end else begin
        chk("prdata_idle", bus.PRDATA, 8'h00);
      end
      chk("csn_isolated", (!prev_csn && !UART_CSN), 1'b0);
      prev_csn = UART_CSN;
      if (!UART_CSN) cnt_csn++;
      if (!UART_WEN) cnt_wen++;
      if (!UART_OEN) cnt_oen++;
    end
  end

  // One full APB transfer; starts and ends 1 time unit after a rising edge.
  task automatic apb(input logic wr, input logic [4:0] addr, input logic [7:0] data,
                     output logic [7:0] rd, output logic err);
    int a;
    logic txrdy_s, txok, rxrd, e;
    a = int'(addr[4:2]);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = data;
    txrdy_s = TXRDY;
    txok = wr && (a == 0) && txrdy_s;
    rxrd = !wr && (a == 1);
    e = model_err(wr, a, data, txrdy_s);
    @(posedge CLK); #1;
    bus.PENABLE = 1'b1;
    if (txok) m_data_in = data;
    exp_csn = !(txok || rxrd); exp_wen = !txok; exp_oen = !rxrd;
    exp_acc = 1'b1; exp_rd = !wr; exp_err = e; exp_prdata = model_read(a);
    #3;
    rd = bus.PRDATA; err = bus.PSLVERR;
    @(posedge CLK); #1;
    if (wr && !e) begin
      case (a)
        2: m_baud[7:0] = data;
        3: begin m_bit8 = data[0]; m_par = data[1]; m_odd = data[2]; m_baud[12:8] = data[7:3]; end
        4: if (data[5]) m_drop = 1'b0;
        5: begin m_frac = data[2:0]; m_ie_rx = data[3]; m_ie_tx = data[4]; m_ie_err = data[5]; end
        default: ;
      endcase
    end
    if (wr && (a == 0) && !txrdy_s) m_drop = 1'b1;
    exp_csn = 1'b1; exp_wen = 1'b1; exp_oen = 1'b1; exp_acc = 1'b0;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic rd_chk(input string name, input logic [4:0] addr, input logic [7:0] exp);
    logic [7:0] rd; logic err;
    apb(1'b0, addr, 8'h00, rd, err);
    chk(name, rd, exp);
  endtask

  initial begin
    logic [7:0] rd;
    logic err;
    int c0, c1, c2;
    model_reset();
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
    UART_DATA_OUT = 0; TXRDY = 0; RXRDY = 0; PARITY_ERR = 0; OVERFLOW = 0; FRAMING_ERR = 0;
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;

    // Reset state
    @(negedge CLK);
    chk("rst_strobes", {UART_CSN, UART_WEN, UART_OEN}, 3'b111);
    chk("rst_intr", INTR, 1'b0);
    chk("rst_baud", BAUD_VAL, 13'h0001);
    @(posedge CLK); #1;
    rd_chk("rst_ctrl1", 5'h08, 8'h01);
    rd_chk("rst_ctrl2", 5'h0C, 8'h01);
    rd_chk("rst_ctrl3", 5'h14, 8'h00);
    rd_chk("rst_status", 5'h10, 8'h00);

    // TX write accepted
    TXRDY = 1'b1;
    c0 = cnt_wen; c1 = cnt_csn;
    apb(1'b1, 5'h00, 8'h5A, rd, err);
    chk("tx_data_in", UART_DATA_IN, 8'h5A);
    chk("tx_wen_pulses", c0 == cnt_wen - 1, 1'b1);
    chk("tx_csn_pulses", c1 == cnt_csn - 1, 1'b1);
    chk("tx_pslverr", err, 1'b0);

    // TX write dropped, then W1C
    TXRDY = 1'b0;
    c0 = cnt_wen;
    apb(1'b1, 5'h00, 8'hA5, rd, err);
    chk("drop_pslverr", err, 1'b1);
    chk("drop_no_strobe", c0 == cnt_wen, 1'b1);
    chk("drop_data_kept", UART_DATA_IN, 8'h5A);
    rd_chk("drop_status", 5'h10, 8'h20);
    apb(1'b1, 5'h10, 8'h20, rd, err);
    chk("w1c_pslverr", err, 1'b0);
    rd_chk("w1c_status", 5'h10, 8'h00);

    // RX path and interrupt latency
    apb(1'b1, 5'h14, 8'h08, rd, err);
    RXRDY = 1'b1; UART_DATA_OUT = 8'h3C;
    @(negedge CLK); chk("intr_lag0", INTR, 1'b0);
    @(negedge CLK); chk("intr_lag1", INTR, 1'b1);
    @(posedge CLK); #1;
    c0 = cnt_oen;
    rd_chk("rx_data", 5'h04, 8'h3C);
    chk("rx_oen_pulses", c0 == cnt_oen - 1, 1'b1);
    rd_chk("rx_status", 5'h10, 8'h02);
    RXRDY = 1'b0;
    apb(1'b1, 5'h14, 8'h00, rd, err);

    // Line configuration
    apb(1'b1, 5'h0C, 8'hFF, rd, err);
    apb(1'b1, 5'h08, 8'h34, rd, err);
    chk("cfg_baud", BAUD_VAL, 13'h1F34);
    chk("cfg_line", {BIT8, PARITY_EN, ODD_N_EVEN}, 3'b111);
    rd_chk("cfg_ctrl2", 5'h0C, 8'hFF);

    // Error responses
    apb(1'b0, 5'h18, 8'h00, rd, err);
    chk("unmapped_err", err, 1'b1);
    chk("unmapped_prdata", rd, 8'h00);
    apb(1'b1, 5'h1C, 8'h55, rd, err);
    chk("unmapped_wr_err", err, 1'b1);
    apb(1'b1, 5'h04, 8'h12, rd, err);
    chk("rx_write_err", err, 1'b1);
    apb(1'b0, 5'h00, 8'h00, rd, err);
    chk("tx_read_err", err, 1'b1);
    apb(1'b1, 5'h10, 8'h21, rd, err);
    chk("status_bad_bits_err", err, 1'b1);

    // Back-to-back TX write then RX read
    TXRDY = 1'b1;
    c0 = cnt_csn; c1 = cnt_wen; c2 = cnt_oen;
    apb(1'b1, 5'h00, 8'h11, rd, err);
    apb(1'b0, 5'h04, 8'h00, rd, err);
    chk("b2b_csn_pulses", cnt_csn - c0, 2);
    chk("b2b_wen_oen", {cnt_wen - c1 == 1, cnt_oen - c2 == 1}, 2'b11);

    // PSEL dropped during access: nothing reaches the core
    c0 = cnt_csn;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 5'h00; bus.PWDATA = 8'hC3;
    @(posedge CLK); #1;
    m_data_in = 8'hC3;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b1;
    @(posedge CLK); #1;
    bus.PENABLE = 1'b0;
    chk("psel_drop_no_strobe", cnt_csn - c0, 0);

    // Reset during an access cycle
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 5'h00; bus.PWDATA = 8'h77;
    @(posedge CLK); #1;
    m_data_in = 8'h77;
    bus.PENABLE = 1'b1;
    exp_csn = 1'b0; exp_wen = 1'b0; exp_acc = 1'b1; exp_rd = 1'b0; exp_err = 1'b0;
    #2;
    chk("rst_mid_pre_wen", UART_WEN, 1'b0);
    RESET_N = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_strobes", {UART_CSN, UART_WEN, UART_OEN}, 3'b111);
    chk("rst_mid_data_in", UART_DATA_IN, 8'h00);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    chk("rst_mid_baud", BAUD_VAL, 13'h0001);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic       wr;
      logic [4:0] addr;
      logic [7:0] data;
      TXRDY       = ($urandom_range(0, 3) != 0);
      RXRDY       = $urandom_range(0, 1);
      PARITY_ERR  = ($urandom_range(0, 7) == 0);
      OVERFLOW    = ($urandom_range(0, 7) == 0);
      FRAMING_ERR = ($urandom_range(0, 7) == 0);
      UART_DATA_OUT = 8'($urandom_range(0, 255));
      wr   = $urandom_range(0, 1);
      addr = 5'($urandom_range(0, 31));
      data = 8'($urandom_range(0, 255));
      if (addr[4:2] == 3'd4 && $urandom_range(0, 1) == 1) data = 8'h20;
      apb(wr, addr, data, rd, err);
      if ($urandom_range(0, 2) == 0) begin
        RXRDY = $urandom_range(0, 1);
        idle($urandom_range(1, 3));
      end
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_apb_regs.md
# uart_apb_regs

APB3 slave register bank that sits directly upstream of the UART core. It converts APB transfers into the core's CSN/WEN/OEN strobes, holds the line configuration (baud value, fraction, data bits, parity), and presents TX/RX data and status to software. It also keeps a sticky dropped-write flag and drives a level interrupt.

## Interface
- BAUD_RESET, 13'd1, reset value of BAUD_VAL
- FRAC_RESET, 3'd0, reset value of BAUD_VAL_FRACTION
- CLK  in  1  system clock, same clock as the UART core
- RESET_N  in  1  asynchronous, active-low reset
- PSEL, PENABLE, PWRITE  in  1 each  APB3 control
- PADDR  in  5  byte address; bits [1:0] ignored
- PWDATA  in  8  write data
- PRDATA  out  8  read data
- PREADY  out  1  tied 1 (zero wait states)
- PSLVERR  out  1  error response
- UART_CSN, UART_WEN, UART_OEN  out  1 each  core strobes, active low
- UART_DATA_IN  out  8  TX byte to core
- UART_DATA_OUT  in  8  RX byte from core
- TXRDY, RXRDY, PARITY_ERR, OVERFLOW, FRAMING_ERR  in  1 each  core status
- BAUD_VAL  out  13; BAUD_VAL_FRACTION  out  3; BIT8, PARITY_EN, ODD_N_EVEN  out  1 each
- INTR  out  1  level interrupt

## Operation
- Phase FSM: IDLE -> SETUP on PSEL & !PENABLE; SETUP -> ACCESS unconditionally; ACCESS -> SETUP if PSEL & !PENABLE, otherwise IDLE.
- Address map:
  - 0x00 TXDATA: write-only; reads return 0.
  - 0x04 RXDATA: read-only; returns UART_DATA_OUT.
  - 0x08 CTRL1: RW; BAUD_VAL[7:0].
  - 0x0C CTRL2: RW; [0] BIT8, [1] PARITY_EN, [2] ODD_N_EVEN, [7:3] BAUD_VAL[12:8].
  - 0x10 STATUS: [0] TXRDY, [1] RXRDY, [2] PARITY_ERR, [3] OVERFLOW, [4] FRAMING_ERR, [5] TX_DROP (sticky; write 1 clears), [7:6] 0.
  - 0x14 CTRL3: RW; [2:0] BAUD_VAL_FRACTION, [3] IE_RX, [4] IE_TX, [5] IE_ERR, [7:6] 0.
- TXDATA write, TXRDY=1 sampled in SETUP:
  - PWDATA is registered into UART_DATA_IN at the end of SETUP.
  - UART_CSN and UART_WEN are low for exactly the ACCESS cycle.
- TXDATA write, TXRDY=0 sampled in SETUP: no strobe; TX_DROP set; PSLVERR=1 in ACCESS.
- RXDATA read: UART_CSN and UART_OEN are low for exactly the ACCESS cycle. PRDATA = UART_DATA_OUT combinationally in that cycle, so the core clears RXRDY/PARITY_ERR after the data has been sampled.
- STATUS read strobes nothing (no side effects).
- Unmapped address (0x18-0x1C), write to RXDATA/STATUS bits other than 5, or read of TXDATA: PSLVERR=1, no side effects.
- INTR = (IE_RX & RXRDY) | (IE_TX & TXRDY) | (IE_ERR & (PARITY_ERR | OVERFLOW | FRAMING_ERR | TX_DROP)), registered.
- CTRL writes take effect on the clock edge that ends ACCESS.

## Timing
- Reset values:
  - PRDATA 0, PSLVERR 0, PREADY 1
  - strobes 1, UART_DATA_IN 0
  - BAUD_VAL = BAUD_RESET, BAUD_VAL_FRACTION = FRAC_RESET
  - BIT8 1, PARITY_EN 0, ODD_N_EVEN 0, IE_* 0, TX_DROP 0, INTR 0, FSM IDLE
- Strobes are registered in SETUP and additionally gated by PSEL & PENABLE. If PSEL drops in ACCESS (protocol violation), no strobe reaches the core.
- PRDATA and PSLVERR are valid only in ACCESS; PRDATA = 0 otherwise.
- Back-to-back transfers (ACCESS directly followed by SETUP) are supported. Strobes never stay low for two consecutive cycles.
- TX_DROP set and W1C clear in the same cycle: set wins.
- INTR lags status inputs by 1 cycle.
- Reset asserted mid-transfer: all strobes return high asynchronously and no partial write is committed.

## Test plan
- Reset -> CTRL1 reads 0x01, CTRL2 reads 0x01, CTRL3 reads 0x00, STATUS[5]=0, INTR=0, all strobes high.
- Write 0x5A to 0x00 with TXRDY=1 -> UART_DATA_IN=0x5A; CSN=WEN=0 for exactly 1 cycle, aligned with ACCESS; PSLVERR=0.
- Write 0xA5 to 0x00 with TXRDY=0 -> no strobe, PSLVERR=1, STATUS reads 0x20 with other inputs 0. Then write 0x20 to 0x10 -> STATUS[5]=0.
- RXRDY=1, UART_DATA_OUT=0x3C, read 0x04 -> PRDATA=0x3C; CSN=OEN=0 for 1 cycle. Set IE_RX first -> INTR=1 one cycle after RXRDY rises.
- Write 0xFF to 0x0C, then 0x34 to 0x08 -> BAUD_VAL=0x1F34, BIT8=PARITY_EN=ODD_N_EVEN=1.
- Access 0x18 -> PSLVERR=1, PRDATA=0. Back-to-back write 0x00 then read 0x04 -> two isolated single-cycle strobes. Assert RESET_N low during ACCESS -> strobes high immediately.
